// File: rtl/proc_drv_pkg.sv
// proc_driver shared types: FSM states, F/R codes, golden ALU function.
// Imported by proc_driver and proc_golden.
package proc_drv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] F_AND  = 3'd0;
  localparam logic [2:0] F_OR   = 3'd1;
  localparam logic [2:0] F_XOR  = 3'd2;
  localparam logic [2:0] F_ONES = 3'd3;
  localparam logic [2:0] F_NAND = 3'd4;
  localparam logic [2:0] F_NOR  = 3'd5;
  localparam logic [2:0] F_XNOR = 3'd6;
  localparam logic [2:0] F_ZERO = 3'd7;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_TOB  = 2'd1;
  localparam logic [1:0] R_TOA  = 2'd2;
  localparam logic [1:0] R_SWAP = 2'd3;

  function automatic logic [3:0] golden_f(
    input logic [2:0] f,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] res;
    unique case (f)
      F_AND:   res = a & b;
      F_OR:    res = a | b;
      F_XOR:   res = a ^ b;
      F_ONES:  res = 4'hF;
      F_NAND:  res = ~(a & b);
      F_NOR:   res = ~(a | b);
      F_XNOR:  res = ~(a ^ b);
      default: res = 4'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/proc_golden.sv
// Shadow A/B register model of the processor, used for result checking.
// Only instantiated when PROC_DRV_CHECK_EN is defined.
module proc_golden
  import proc_drv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ld_a_i,
  input  logic       ld_b_i,
  input  logic       exec_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] f_i,
  input  logic [1:0] r_i,
  output logic [3:0] sh_a_o,
  output logic [3:0] sh_b_o
);

  logic [3:0] sh_a_q, sh_a_d;
  logic [3:0] sh_b_q, sh_b_d;
  logic [3:0] res;

  // Next shadow: loads copy Din, execute routes the ALU result.
  always_comb begin
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    res    = golden_f(f_i, sh_a_q, sh_b_q);
    if (ld_a_i) sh_a_d = a_i;
    if (ld_b_i) sh_b_d = b_i;
    if (exec_i) begin
      unique case (r_i)
        R_TOB:   sh_b_d = res;
        R_TOA:   sh_a_d = res;
        R_SWAP: begin
          sh_a_d = sh_b_q;
          sh_b_d = sh_a_q;
        end
        default: ;
      endcase
    end
  end

  // Shadow register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
    end else begin
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
    end
  end

  assign sh_a_o = sh_a_q;
  assign sh_b_o = sh_b_q;

endmodule

// File: rtl/proc_driver.sv
// Command-driven sequencer for a 4-bit switch/strobe processor.
// Define PROC_DRV_CHECK_EN to add the shadow model and rsp_err check.
module proc_driver
  import proc_drv_pkg::*;
#(
  parameter int EXEC_CYCLES  = 8,
  parameter int PULSE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_f,
  input  logic [1:0] cmd_r,
  input  logic       cmd_load_a,
  input  logic       cmd_load_b,
  output logic       LoadA,
  output logic       LoadB,
  output logic       Execute,
  output logic [3:0] Din,
  output logic [2:0] F,
  output logic [1:0] R,
  input  logic [3:0] Aval,
  input  logic [3:0] Bval,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_a,
  output logic [3:0] rsp_b,
  output logic       rsp_err
);

  localparam logic [7:0] PW = 8'(PULSE_CYCLES);
  localparam logic [7:0] EW = 8'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] f_q, f_d;
  logic [1:0] r_q, r_d;
  logic       lb_q, lb_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic       cap;
  logic       ld_a_en;
  logic       ld_b_en;
  logic       ex_en;
  logic       ex_last;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    f_d       = f_q;
    r_d       = r_q;
    lb_d      = lb_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    cap       = 1'b0;
    ex_last   = 1'b0;
    cmd_ready = (state_q == S_IDLE);
    ld_a_en   = (state_q == S_LDA) && (cnt_q < PW);
    ld_b_en   = (state_q == S_LDB) && (cnt_q < PW);
    ex_en     = (state_q == S_EXEC);
    Din       = 4'h0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d   = cmd_a;
          b_d   = cmd_b;
          f_d   = cmd_f;
          r_d   = cmd_r;
          lb_d  = cmd_load_b;
          cnt_d = '0;
          if (cmd_load_a)      state_d = S_LDA;
          else if (cmd_load_b) state_d = S_LDB;
          else                 state_d = S_EXEC;
        end
      end
      S_LDA: begin
        Din = a_q;
        if (cnt_q == PW) begin
          cnt_d   = '0;
          state_d = lb_q ? S_LDB : S_EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LDB: begin
        Din = b_q;
        if (cnt_q == PW) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == PW - 8'd1) begin
          ex_last = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == EW) begin
          cap     = 1'b1;
          ra_d    = Aval;
          rb_d    = Bval;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          f_d     = '0;
          r_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    LoadA   = ~ld_a_en;
    LoadB   = ~ld_b_en;
    Execute = ~ex_en;
  end

  // State, counter, command and response registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      r_q     <= '0;
      lb_q    <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      r_q     <= r_d;
      lb_q    <= lb_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
    end
  end

  assign F         = f_q;
  assign R         = r_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_a     = ra_q;
  assign rsp_b     = rb_q;

`ifdef PROC_DRV_CHECK_EN
  logic [3:0] sh_a;
  logic [3:0] sh_b;
  logic       err_q;

  proc_golden u_golden (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .ld_a_i (ld_a_en),
    .ld_b_i (ld_b_en),
    .exec_i (ex_last),
    .a_i    (a_q),
    .b_i    (b_q),
    .f_i    (f_q),
    .r_i    (r_q),
    .sh_a_o (sh_a),
    .sh_b_o (sh_b)
  );

  // Flag a processor/shadow mismatch at capture time.
  always_ff @(posedge Clk) begin
    if (Reset)
      err_q <= 1'b0;
    else if (cap)
      err_q <= (Aval != sh_a) || (Bval != sh_b);
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
